// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: state encodings and default width for the bit-serial adder
package serial_add_ctrl_pkg;
  localparam int WIDTH_DEFAULT = 8;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
endpackage

// File: rtl/serial_add_ctrl_fa.sv
// serial_add_ctrl_fa: 1-bit full adder built from two half adders plus an OR
module serial_add_ctrl_ha (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_add_ctrl_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);
  logic s1, c1, c2;
  serial_add_ctrl_ha u_h0 (.x(a),  .y(b),   .s(s1), .c(c1));
  serial_add_ctrl_ha u_h1 (.x(s1), .y(cin), .s(s),  .c(c2));
  assign cout = c1 | c2;
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: WIDTH-bit addition sequenced LSB-first through one full adder
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = $clog2(WIDTH) > 0 ? $clog2(WIDTH) : 1;
  state_t           state;
  logic [WIDTH-1:0] opa, opb;
  logic [CW-1:0]    cnt;
  logic             carry, s, c, last;
  serial_add_ctrl_fa u_fa (.a(opa[0]), .b(opb[0]), .cin(carry), .s(s), .cout(c));
  assign last = cnt == CW'(WIDTH - 1);
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      opa   <= '0;
      opb   <= '0;
      carry <= 1'b0;
      cnt   <= '0;
      sum   <= '0;
      cout  <= 1'b0;
    end else
      case (state)
        IDLE:
          if (start) begin
            opa   <= a;
            opb   <= b;
            carry <= cin;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            state <= RUN;
          end
        RUN: begin
          sum   <= {s, sum[WIDTH-1:1]};
          opa   <= opa >> 1;
          opb   <= opb >> 1;
          carry <= c;
          // counter saturates on the final bit so it never wraps
          cnt   <= last ? cnt : cnt + 1'b1;
          if (last) begin
            cout  <= c;
            state <= DONE;
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
  assign busy = state == RUN;
  assign done = state == DONE;
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: scoreboard bench for the bit-serial adder at WIDTH 8 and 4
module tb_serial_add_ctrl;
  typedef struct {logic [8:0] val; int due;} exp_t;
  logic       clk = 0, rst = 1, rst4 = 1;
  logic       start8 = 0, cin8 = 0, start4 = 0, cin4 = 0;
  logic [7:0] a8 = 0, b8 = 0, sum8;
  logic [3:0] a4 = 0, b4 = 0, sum4;
  logic       busy8, done8, cout8, busy4, done4, cout4;
  int         cyc = 0, tests = 0, fails = 0, run8 = 0, run4 = 0;
  exp_t       q8[$], q4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  serial_add_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .cin(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .cout(cout8));
  serial_add_ctrl #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst4), .start(start4), .a(a4), .b(b4), .cin(cin4),
    .busy(busy4), .done(done4), .sum(sum4), .cout(cout4));

  task automatic chk(string name, logic [31:0] got, logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h expected=%0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [8:0] add9(logic [7:0] x, logic [7:0] y, logic c);
    return {1'b0, x} + {1'b0, y} + {8'd0, c};
  endfunction

  task automatic go8(logic [7:0] x, logic [7:0] y, logic c, bit expect_result);
    @(posedge clk); #1;
    a8 = x; b8 = y; cin8 = c; start8 = 1;
    if (expect_result) q8.push_back('{add9(x, y, c), cyc + 9});
    @(posedge clk); #1;
    start8 = 0;
  endtask

  task automatic drain8(int budget);
    int n = 0;
    while (q8.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (q8.size() > 0) begin
      chk("drain8_timeout", q8.size(), 0);
      q8.delete();
    end
  endtask

  task automatic drain4(int budget);
    int n = 0;
    while (q4.size() > 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    if (q4.size() > 0) begin
      chk("drain4_timeout", q4.size(), 0);
      q4.delete();
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (done8) begin
      chk("busy8_len", run8, 8);
      run8 = 0;
      if (q8.size() == 0) chk("done8_unexpected", done8, 0);
      else begin
        e = q8.pop_front();
        chk("sum8", {cout8, sum8}, e.val);
        chk("lat8", cyc, e.due);
      end
    end else run8 = busy8 ? run8 + 1 : 0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (done4) begin
      chk("busy4_len", run4, 4);
      run4 = 0;
      if (q4.size() == 0) chk("done4_unexpected", done4, 0);
      else begin
        e = q4.pop_front();
        chk("sum4", {cout4, sum4}, e.val);
        chk("lat4", cyc, e.due);
      end
    end else run4 = busy4 ? run4 + 1 : 0;
  end

  initial begin
    #300000;
    $display("FAIL global_timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy8", busy8, 0);
    chk("rst_done8", done8, 0);
    chk("rst_sum8", sum8, 0);
    chk("rst_cout8", cout8, 0);
    chk("rst_busy4", busy4, 0);
    chk("rst_sum4", sum4, 0);
    @(posedge clk); #1;
    rst = 0; rst4 = 0;
    go8(8'h5A, 8'h3C, 0, 1);
    drain8(40);
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("hold_sum8", sum8, 8'h96);
    chk("hold_cout8", cout8, 0);
    go8(8'hFF, 8'h01, 0, 1);
    drain8(40);
    go8(8'hFF, 8'h00, 1, 1);
    drain8(40);
    go8(8'h00, 8'h00, 0, 1);
    drain8(40);
    // start held high with fresh operands every cycle: only every 10th is accepted
    for (int k = 0; k < 30; k++) begin
      @(posedge clk); #1;
      start8 = 1;
      a8 = 8'(k * 37 + 5);
      b8 = 8'(k * 91 + 17);
      cin8 = k[0];
      if (k % 10 == 0) q8.push_back('{add9(a8, b8, cin8), cyc + 9});
    end
    @(posedge clk); #1;
    start8 = 0;
    drain8(40);
    @(posedge clk); #1;
    a8 = 8'h12; b8 = 8'h34; cin8 = 0; start8 = 1;
    q8.push_back('{9'h046, cyc + 9});
    @(posedge clk); #1;
    start8 = 0;
    repeat (2) @(posedge clk);
    #1;
    a8 = 8'hFF; b8 = 8'hFF; cin8 = 1;
    drain8(40);
    go8(8'h33, 8'h44, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    @(negedge clk);
    chk("midrst_busy8", busy8, 0);
    chk("midrst_done8", done8, 0);
    chk("midrst_sum8", sum8, 0);
    chk("midrst_cout8", cout8, 0);
    @(posedge clk); #1;
    rst = 0;
    repeat (15) @(posedge clk);
    go8(8'h80, 8'h80, 0, 1);
    drain8(40);
    for (int i = 0; i < 512; i++) begin
      @(posedge clk); #1;
      a4 = 4'(i >> 5);
      b4 = 4'(i >> 1);
      cin4 = i[0];
      start4 = 1;
      q4.push_back('{9'({1'b0, a4} + {1'b0, b4} + {4'd0, cin4}), cyc + 5});
      @(posedge clk); #1;
      start4 = 0;
      repeat (4) @(posedge clk);
    end
    drain4(40);
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
